ringosc_bank: RTL and testbench

RINGOSC_BANK -- requirements
Module: ringosc_bank

---
 rtl/ringosc_pkg.sv | 18 +
 rtl/ringosc_ring.sv | 38 +++
 rtl/ringosc_bank.sv | 206 ++++++++++++++++++++
 tb/tb_ringosc_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringosc_pkg.sv
// ringosc_pkg: shared state encoding and fixed constants for the ring-oscillator bank.
package ringosc_pkg;

    // Measurement FSM state encoding.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_COUNT  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Cycles spent flushing the synchronizer before edges are counted.
    localparam int SETTLE_LEN = 4;

    // Number of toggle flops in the ripple prescaler.
    localparam int PS_DEPTH = 7;

endpackage

// File: rtl/ringosc_ring.sv
// ringosc_ring: one NAND-gated ring oscillator.
// With USE_MODEL set, the loop is replaced by an externally supplied waveform
// so that a simulator can run the bank without an unresolvable combinational loop.
module ringosc_ring
    import ringosc_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter bit USE_MODEL = 1'b0
) (
    input  logic enable,
    input  logic model_wave,
    output logic osc_out
);

    if (USE_MODEL) begin : g_model
        // The modelled ring follows the supplied waveform while enabled and sits low otherwise.
        assign osc_out = enable & model_wave;

        logic [7:0] unused_stage_count;
        assign unused_stage_count = 8'(STAGES);
    end else begin : g_loop
        // node[0] is the NAND gate, the rest are inverters; STAGES is odd so the loop inverts.
        (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] node;

        assign node[0] = ~(enable & node[STAGES-1]);

        for (genvar s = 1; s < STAGES; s++) begin : g_inv
            assign node[s] = ~node[s-1];
        end

        // When disabled the NAND output is stuck high, so its inverse gives a quiet 0.
        assign osc_out = ~node[0];

        logic unused_model;
        assign unused_model = model_wave;
    end

endmodule

// File: rtl/ringosc_bank.sv
// ringosc_bank: bank of gated ring oscillators with a prescaler, a clk-domain
// synchronizer and a gated edge counter that measures the selected ring.
module ringosc_bank
    import ringosc_pkg::*;
#(
    parameter int NUM_RINGS   = 4,
    parameter int BASE_STAGES = 3,
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter bit USE_MODEL   = 1'b0,
    localparam int SEL_W      = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1,
    localparam int PS_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [SEL_W-1:0]     ring_sel,
    input  logic [PS_W-1:0]      prescale,
    input  logic [WIN_W-1:0]     window,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_RINGS-1:0] model_wave,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    output logic                 osc_out
);

    localparam int SETTLE_W = $clog2(SETTLE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               state_next;
    logic [SEL_W-1:0]     sel_q;
    logic [PS_W-1:0]      ps_q;
    logic [WIN_W-1:0]     rem;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]     acc;
    logic [CNT_W-1:0]     acc_next;
    logic                 ovf_acc;
    logic                 ovf_next;

    logic [SEL_W-1:0]     active_sel;
    logic [PS_W-1:0]      active_ps;
    logic [NUM_RINGS-1:0] ring_out;
    logic [PS_DEPTH:0]    tap;
    logic                 tap_sel;
    logic                 sync1;
    logic                 sync2;
    logic                 sync3;
    logic                 edge_seen;

    assign busy = (state == ST_SETTLE) || (state == ST_COUNT);
    assign done = (state == ST_DONE);

    // While busy the latched choices rule, so input changes mid-run are ignored.
    assign active_sel = busy ? sel_q : ring_sel;
    assign active_ps  = busy ? ps_q  : prescale;

    for (genvar k = 0; k < NUM_RINGS; k++) begin : g_ring
        logic ring_en;
        assign ring_en = enable && (active_sel == SEL_W'(k));

        ringosc_ring #(
            .STAGES    (BASE_STAGES + 2 * k),
            .USE_MODEL (USE_MODEL)
        ) u_ring (
            .enable     (ring_en),
            .model_wave (model_wave[k]),
            .osc_out    (ring_out[k])
        );
    end

    // Only the active ring can be non-zero, so an OR acts as the output mux.
    assign osc_out = |ring_out;

    assign tap[0] = osc_out;

    for (genvar i = 0; i < PS_DEPTH; i++) begin : g_div
        logic div_q;

        // Each toggle flop halves the frequency of the tap below it.
        always_ff @(posedge tap[i] or posedge rst) begin
            if (rst) begin
                div_q <= 1'b0;
            end else begin
                div_q <= ~div_q;
            end
        end

        assign tap[i+1] = div_q;
    end

    assign tap_sel = tap[active_ps];

    // Two-flop synchronizer into clk plus a history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= tap_sel;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_seen = sync2 & ~sync3;

    // Saturating edge counter; an edge arriving at the ceiling raises the overflow flag instead.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf_acc;
        if ((state == ST_COUNT) && edge_seen) begin
            if (acc == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                acc_next = acc + CNT_W'(1);
            end
        end
    end

    // Next-state logic; abort takes priority over start and over window expiry.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = (window == '0) ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (settle_cnt == SETTLE_W'(SETTLE_LEN - 1)) begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (rem == WIN_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, latched request parameters, counters and the published result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel_q      <= '0;
            ps_q       <= '0;
            rem        <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (window != '0) begin
                            sel_q      <= ring_sel;
                            ps_q       <= prescale;
                            rem        <= window;
                            settle_cnt <= '0;
                            acc        <= '0;
                            ovf_acc    <= 1'b0;
                        end else begin
                            count    <= '0;
                            overflow <= 1'b0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!abort) begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (!abort) begin
                        acc     <= acc_next;
                        ovf_acc <= ovf_next;
                        rem     <= rem - WIN_W'(1);
                        if (rem == WIN_W'(1)) begin
                            count    <= acc_next;
                            overflow <= ovf_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ringosc_bank.sv
// tb_ringosc_bank: directed bench for the ring-oscillator bank using modelled rings.
module tb_ringosc_bank;

    localparam int CNT_W       = 16;
    localparam int WIN_W       = 16;
    localparam int SMALL_CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             start;
    logic             abort;
    logic [1:0]       ring_sel;
    logic [2:0]       prescale;
    logic [WIN_W-1:0] window;
    logic             wave0;
    logic             wave1;
    logic             wave2;
    logic             wave3;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             osc_out;

    logic                   s_start;
    logic [WIN_W-1:0]       s_window;
    logic                   s_wave;
    logic                   s_busy;
    logic                   s_done;
    logic [SMALL_CNT_W-1:0] s_count;
    logic                   s_overflow;
    logic                   s_osc_out;

    int tests_run;
    int tests_failed;
    int cycles;
    int pulses;
    logic saw_busy;

    ringosc_bank #(
        .NUM_RINGS (4),
        .CNT_W     (CNT_W),
        .WIN_W     (WIN_W),
        .USE_MODEL (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ring_sel   (ring_sel),
        .prescale   (prescale),
        .window     (window),
        .start      (start),
        .abort      (abort),
        .model_wave ({wave3, wave2, wave1, wave0}),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .overflow   (overflow),
        .osc_out    (osc_out)
    );

    ringosc_bank #(
        .NUM_RINGS (4),
        .CNT_W     (SMALL_CNT_W),
        .WIN_W     (WIN_W),
        .USE_MODEL (1'b1)
    ) dut_small (
        .clk        (clk),
        .rst        (rst),
        .enable     (1'b1),
        .ring_sel   (2'd0),
        .prescale   (3'd0),
        .window     (s_window),
        .start      (s_start),
        .abort      (1'b0),
        .model_wave ({3'b000, s_wave}),
        .busy       (s_busy),
        .done       (s_done),
        .count      (s_count),
        .overflow   (s_overflow),
        .osc_out    (s_osc_out)
    );

    // 10-unit clock, rising edges at 5 mod 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring waveforms: periods of 7, 5, 9, 6 and 4 clk cycles, toggling at 2 mod 5 so they never meet a clk edge.
    initial begin wave0 = 1'b0; #2; forever #35 wave0 = ~wave0; end
    initial begin wave1 = 1'b0; #2; forever #25 wave1 = ~wave1; end
    initial begin wave2 = 1'b0; #2; forever #45 wave2 = ~wave2; end
    initial begin wave3 = 1'b0; #2; forever #30 wave3 = ~wave3; end
    initial begin s_wave = 1'b0; #2; forever #20 s_wave = ~s_wave; end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Sets up a request and holds start for exactly one sampled edge.
    task automatic applyStimulus(input logic [1:0] sel, input logic [2:0] ps, input logic [WIN_W-1:0] win);
        ring_sel = sel;
        prescale = ps;
        window   = win;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Advances until done, reporting the cycle number done appeared on and whether busy was ever seen.
    task automatic waitDone(input int budget, input int first_cycle, output int seen_cycle, output logic seen_busy);
        seen_cycle = first_cycle;
        seen_busy  = busy;
        while (!done && seen_cycle < budget) begin
            @(posedge clk);
            #1;
            seen_cycle++;
            if (busy) seen_busy = 1'b1;
        end
        checkOutput("done_seen", done, 1);
    endtask

    task automatic waitSmallDone(input int budget, output int seen_cycle);
        seen_cycle = 1;
        while (!s_done && seen_cycle < budget) begin
            @(posedge clk);
            #1;
            seen_cycle++;
        end
        checkOutput("small_done_seen", s_done, 1);
    endtask

    // Counts done pulses over a stretch of cycles.
    task automatic countDone(input int n, output int seen_pulses);
        seen_pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_pulses++;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        ring_sel = 2'd0;
        prescale = 3'd0;
        window   = '0;
        s_start  = 1'b0;
        s_window = '0;

        #1 rst = 1'b1;
        #10;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_small_overflow", s_overflow, 0);
        stepCycle();
        rst    = 1'b0;
        enable = 1'b1;
        repeat (3) stepCycle();
        checkOutput("osc_follows_ring0", osc_out, wave0);
        checkOutput("small_osc_follows_ring", s_osc_out, s_wave);

        // Period 7, undivided, 70-cycle gate: ten edges and done on cycle 75.
        applyStimulus(2'd0, 3'd0, 16'd70);
        waitDone(200, 1, cycles, saw_busy);
        checkOutput("t1_latency", cycles, 75);
        checkOutput("t1_count", count, 10);
        checkOutput("t1_overflow", overflow, 0);
        checkOutput("t1_busy_seen", saw_busy, 1);
        stepCycle();
        checkOutput("t1_done_one_cycle", done, 0);
        checkOutput("t1_busy_after", busy, 0);

        // Zero window: done on the very next cycle with a zero result and no busy.
        applyStimulus(2'd0, 3'd0, 16'd0);
        waitDone(10, 1, cycles, saw_busy);
        checkOutput("w0_latency", cycles, 1);
        checkOutput("w0_count", count, 0);
        checkOutput("w0_overflow", overflow, 0);
        checkOutput("w0_busy_seen", saw_busy, 0);
        stepCycle();

        // Prescale by 4: divided period 28, 280-cycle gate gives ten edges.
        applyStimulus(2'd0, 3'd2, 16'd280);
        waitDone(400, 1, cycles, saw_busy);
        checkOutput("t2_latency", cycles, 285);
        checkOutput("t2_count", count, 10);
        stepCycle();

        // Abort during COUNT cycle 20: idle next cycle, result untouched, no done ever.
        applyStimulus(2'd1, 3'd0, 16'd60);
        repeat (23) stepCycle();
        checkOutput("abort_busy_before", busy, 1);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abort_busy_after", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_count_kept", count, 10);
        countDone(80, pulses);
        checkOutput("abort_no_done", pulses, 0);

        // Ring 1 (period 5) latched; mid-run changes and a repeated start are ignored.
        applyStimulus(2'd1, 3'd0, 16'd60);
        ring_sel = 2'd0;
        prescale = 3'd3;
        window   = 16'd5;
        start    = 1'b1;
        stepCycle();
        start    = 1'b0;
        waitDone(200, 2, cycles, saw_busy);
        checkOutput("latched_latency", cycles, 65);
        checkOutput("latched_count", count, 12);
        stepCycle();

        // Global enable low: no ring output and no edges counted.
        enable = 1'b0;
        stepCycle();
        checkOutput("disabled_osc", osc_out, 0);
        applyStimulus(2'd0, 3'd0, 16'd70);
        waitDone(200, 1, cycles, saw_busy);
        checkOutput("disabled_count", count, 0);
        checkOutput("disabled_latency", cycles, 75);
        stepCycle();
        enable = 1'b1;

        // Nonzero result, then reset in the middle of COUNT.
        applyStimulus(2'd1, 3'd0, 16'd30);
        waitDone(100, 1, cycles, saw_busy);
        checkOutput("pre_reset_count", count, 6);
        stepCycle();
        applyStimulus(2'd0, 3'd0, 16'd70);
        repeat (30) stepCycle();
        checkOutput("rst_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_overflow", overflow, 0);
        stepCycle();
        rst = 1'b0;
        countDone(100, pulses);
        checkOutput("rst_no_done", pulses, 0);
        checkOutput("rst_idle", busy, 0);
        applyStimulus(2'd1, 3'd0, 16'd30);
        waitDone(100, 1, cycles, saw_busy);
        checkOutput("post_reset_latency", cycles, 35);
        checkOutput("post_reset_count", count, 6);
        stepCycle();

        // 4-bit counter, period 4, 100-cycle gate: 25 edges saturate at 15 with overflow.
        s_window = 16'd100;
        s_start  = 1'b1;
        stepCycle();
        s_start  = 1'b0;
        waitSmallDone(200, cycles);
        checkOutput("sat_latency", cycles, 105);
        checkOutput("sat_count", s_count, 15);
        checkOutput("sat_overflow", s_overflow, 1);
        stepCycle();
        s_window = 16'd0;
        s_start  = 1'b1;
        stepCycle();
        s_start  = 1'b0;
        waitSmallDone(10, cycles);
        checkOutput("sat_clear_count", s_count, 0);
        checkOutput("sat_clear_overflow", s_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
